// File: rtl/node_line_scheduler.sv
// node_line_scheduler
//
// Per-scanline sprite scheduler for the rope renderer. At the first hblank
// column of each line it walks every rope node once (one node per clk),
// collects the nodes whose ball bounding box covers the *next* scanline and
// publishes them as a short, index-ordered slot list for the pixel stage.
//
// The scan works on a snapshot of the node buses, so the rope may keep
// moving while the scan runs. Results are built in a back list and copied
// to the outputs in a single COMMIT cycle. The outputs therefore only ever
// change on that one edge.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high; returns to IDLE, clears everything
//   nodes_x     NODES x 10-bit node top-left x, node i at [10*i+9:10*i]
//   nodes_y     NODES x 10-bit node top-left y, same packing
//   pix_x       current scan column; pix_x == SCAN_X starts a scan
//   pix_y       current scan line; the scan targets the following line
//   slot_valid  per-slot "holds a node" flag, filled from slot 0 upward
//   slot_x      per-slot node x (10 bits each)
//   slot_dy     per-slot row inside the ball, 0..BALL_SIZE-1 (4 bits each)
//   slot_id     per-slot node index (5 bits each)
//   overflow    more than SLOTS nodes covered the target line
//   busy        high from the cycle after the trigger through COMMIT

module node_line_scheduler #(
    parameter int NODES     = 20,
    parameter int SLOTS     = 4,
    parameter int BALL_SIZE = 10,
    parameter int SCAN_X    = 640,
    parameter int V_LAST    = 524
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [10*NODES-1:0] nodes_x,
    input  logic [10*NODES-1:0] nodes_y,
    input  logic [9:0]          pix_x,
    input  logic [9:0]          pix_y,
    output logic [SLOTS-1:0]    slot_valid,
    output logic [10*SLOTS-1:0] slot_x,
    output logic [4*SLOTS-1:0]  slot_dy,
    output logic [5*SLOTS-1:0]  slot_id,
    output logic                overflow,
    output logic                busy
);

    localparam int IDX_W = (NODES > 1) ? $clog2(NODES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NODES - 1);
    localparam logic [9:0]       SCAN_X_V = 10'(SCAN_X);
    localparam logic [9:0]       V_LAST_V = 10'(V_LAST);
    localparam logic [10:0]      BALL_V   = 11'(BALL_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_COMMIT
    } state_t;

    state_t state_q, state_d;

    logic             trig_prev_q, trig_prev_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [9:0]       target_q, target_d;

    // Node snapshot taken at the trigger edge
    logic [9:0] snap_x_q [NODES];
    logic [9:0] snap_x_d [NODES];
    logic [9:0] snap_y_q [NODES];
    logic [9:0] snap_y_d [NODES];

    // Back list, filled during SCAN
    logic [SLOTS-1:0] back_valid_q, back_valid_d;
    logic [9:0]       back_x_q  [SLOTS];
    logic [9:0]       back_x_d  [SLOTS];
    logic [3:0]       back_dy_q [SLOTS];
    logic [3:0]       back_dy_d [SLOTS];
    logic [4:0]       back_id_q [SLOTS];
    logic [4:0]       back_id_d [SLOTS];
    logic             back_ovf_q, back_ovf_d;

    // Published list
    logic [SLOTS-1:0] out_valid_q, out_valid_d;
    logic [9:0]       out_x_q  [SLOTS];
    logic [9:0]       out_x_d  [SLOTS];
    logic [3:0]       out_dy_q [SLOTS];
    logic [3:0]       out_dy_d [SLOTS];
    logic [4:0]       out_id_q [SLOTS];
    logic [4:0]       out_id_d [SLOTS];
    logic             out_ovf_q, out_ovf_d;

    logic        scan_cond;
    logic        trigger;
    logic [9:0]  cur_x;
    logic [9:0]  cur_y;
    logic [10:0] cur_y_ext;
    logic [10:0] target_ext;
    logic        hit;
    logic [3:0]  hit_dy;
    logic        placed;

    // Edge-detect the trigger column so a pixel clock slower than clk
    // (pix_x held at SCAN_X for several clk cycles) starts only one scan.
    assign scan_cond = (pix_x == SCAN_X_V);
    assign trigger   = scan_cond && !trig_prev_q;

    assign cur_x = snap_x_q[idx_q];
    assign cur_y = snap_y_q[idx_q];

    // Compare in 11 bits so a ball near y=1023 cannot wrap its bottom edge
    // around to small line numbers.
    assign cur_y_ext  = {1'b0, cur_y};
    assign target_ext = {1'b0, target_q};
    assign hit        = (cur_y_ext <= target_ext) && (target_ext < cur_y_ext + BALL_V);
    assign hit_dy     = 4'(target_q - cur_y);

    always_comb begin
        state_d      = state_q;
        trig_prev_d  = scan_cond;
        idx_d        = idx_q;
        target_d     = target_q;
        snap_x_d     = snap_x_q;
        snap_y_d     = snap_y_q;
        back_valid_d = back_valid_q;
        back_x_d     = back_x_q;
        back_dy_d    = back_dy_q;
        back_id_d    = back_id_q;
        back_ovf_d   = back_ovf_q;
        out_valid_d  = out_valid_q;
        out_x_d      = out_x_q;
        out_dy_d     = out_dy_q;
        out_id_d     = out_id_q;
        out_ovf_d    = out_ovf_q;
        placed       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d  = ST_SCAN;
                    idx_d    = '0;
                    target_d = (pix_y == V_LAST_V) ? 10'd0 : pix_y + 10'd1;
                    for (int i = 0; i < NODES; i++) begin
                        snap_x_d[i] = nodes_x[10*i +: 10];
                        snap_y_d[i] = nodes_y[10*i +: 10];
                    end
                    back_valid_d = '0;
                    back_ovf_d   = 1'b0;
                    for (int k = 0; k < SLOTS; k++) begin
                        back_x_d[k]  = '0;
                        back_dy_d[k] = '0;
                        back_id_d[k] = '0;
                    end
                end
            end

            ST_SCAN: begin
                if (hit) begin
                    // Slots fill in node-index order, so the lowest free
                    // slot is always directly after the last used one.
                    for (int k = 0; k < SLOTS; k++) begin
                        if (!placed && !back_valid_q[k]) begin
                            back_valid_d[k] = 1'b1;
                            back_x_d[k]     = cur_x;
                            back_dy_d[k]    = hit_dy;
                            back_id_d[k]    = 5'(idx_q);
                            placed          = 1'b1;
                        end
                    end
                    if (!placed) begin
                        back_ovf_d = 1'b1;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_COMMIT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            ST_COMMIT: begin
                out_valid_d = back_valid_q;
                out_x_d     = back_x_q;
                out_dy_d    = back_dy_q;
                out_id_d    = back_id_q;
                out_ovf_d   = back_ovf_q;
                state_d     = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            trig_prev_q  <= 1'b0;
            idx_q        <= '0;
            target_q     <= '0;
            snap_x_q     <= '{default: '0};
            snap_y_q     <= '{default: '0};
            back_valid_q <= '0;
            back_x_q     <= '{default: '0};
            back_dy_q    <= '{default: '0};
            back_id_q    <= '{default: '0};
            back_ovf_q   <= 1'b0;
            out_valid_q  <= '0;
            out_x_q      <= '{default: '0};
            out_dy_q     <= '{default: '0};
            out_id_q     <= '{default: '0};
            out_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            trig_prev_q  <= trig_prev_d;
            idx_q        <= idx_d;
            target_q     <= target_d;
            snap_x_q     <= snap_x_d;
            snap_y_q     <= snap_y_d;
            back_valid_q <= back_valid_d;
            back_x_q     <= back_x_d;
            back_dy_q    <= back_dy_d;
            back_id_q    <= back_id_d;
            back_ovf_q   <= back_ovf_d;
            out_valid_q  <= out_valid_d;
            out_x_q      <= out_x_d;
            out_dy_q     <= out_dy_d;
            out_id_q     <= out_id_d;
            out_ovf_q    <= out_ovf_d;
        end
    end

    for (genvar k = 0; k < SLOTS; k++) begin : g_out
        assign slot_x[10*k +: 10] = out_x_q[k];
        assign slot_dy[4*k +: 4]  = out_dy_q[k];
        assign slot_id[5*k +: 5]  = out_id_q[k];
    end

    assign slot_valid = out_valid_q;
    assign overflow   = out_ovf_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_node_line_scheduler.sv
// Directed bench for node_line_scheduler: a table of single-scan vectors
// plus hand-written sequences for snapshot/retrigger and reset mid-scan.

module tb_node_line_scheduler;

    localparam int NODES = 20;
    localparam int SLOTS = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [10*NODES-1:0] nodes_x;
    logic [10*NODES-1:0] nodes_y;
    logic [9:0]          pix_x;
    logic [9:0]          pix_y;
    logic [SLOTS-1:0]    slot_valid;
    logic [10*SLOTS-1:0] slot_x;
    logic [4*SLOTS-1:0]  slot_dy;
    logic [5*SLOTS-1:0]  slot_id;
    logic                overflow;
    logic                busy;

    node_line_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .nodes_x    (nodes_x),
        .nodes_y    (nodes_y),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .slot_valid (slot_valid),
        .slot_x     (slot_x),
        .slot_dy    (slot_dy),
        .slot_id    (slot_id),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] mask;   // nodes placed at y; the rest sit at y=400
        logic [9:0]  y;
        logic [9:0]  xb;     // node i has x = xb + i
        logic [9:0]  py;
        logic [3:0]  ev;     // expected slot_valid
        logic [19:0] eid;    // expected ids, slot 3..0
        logic [15:0] edy;    // expected dy, slot 3..0
        logic        eovf;
    } vec_t;

    vec_t vecs [10];

    int n_vec = 0;
    int n_bad = 0;
    int busy_cnt;
    logic [3:0] prev_ev;
    logic       prev_eovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_nodes(input logic [19:0] mask, input logic [9:0] y, input logic [9:0] xb);
        for (int i = 0; i < NODES; i++) begin
            nodes_x[10*i +: 10] = 10'(xb + 10'(i));
            nodes_y[10*i +: 10] = mask[i] ? y : 10'd400;
        end
    endtask

    // Trigger one scan, count busy cycles and check the old list is held
    // until the commit edge. Returns after edge 22.
    task automatic do_scan(input string tag, input logic [19:0] mask, input logic [9:0] y,
                           input logic [9:0] xb, input logic [9:0] py);
        @(negedge clk);
        set_nodes(mask, y, xb);
        pix_y = py;
        pix_x = 10'd640;
        @(posedge clk);            // edge 0
        busy_cnt = 0;
        for (int e = 0; e <= 22; e++) begin
            if (e > 0) @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            if (e == 3) pix_x = 10'd0;
            if (e == 20) begin
                check({tag, "_hold_valid"}, 32'(slot_valid), 32'(prev_ev));
                check({tag, "_hold_ovf"}, 32'(overflow), 32'(prev_eovf));
            end
        end
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd21);
    endtask

    task automatic check_list(input string tag, input vec_t v);
        check({tag, "_valid"}, 32'(slot_valid), 32'(v.ev));
        check({tag, "_ovf"}, 32'(overflow), 32'(v.eovf));
        for (int k = 0; k < SLOTS; k++) begin
            if (v.ev[k]) begin
                check($sformatf("%s_id%0d", tag, k), 32'(slot_id[5*k +: 5]), 32'(v.eid[5*k +: 5]));
                check($sformatf("%s_dy%0d", tag, k), 32'(slot_dy[4*k +: 4]), 32'(v.edy[4*k +: 4]));
                check($sformatf("%s_x%0d", tag, k), 32'(slot_x[10*k +: 10]),
                      32'(10'(v.xb + 10'(v.eid[5*k +: 5]))));
            end
        end
        prev_ev   = v.ev;
        prev_eovf = v.eovf;
    endtask

    initial begin
        vec_t va;

        vecs[0] = '{20'h00008, 10'd50,   10'd97,  10'd49,   4'b0001, {5'd0, 5'd0, 5'd0, 5'd3}, 16'h0000, 1'b0};
        vecs[1] = '{20'h00001, 10'd50,   10'd10,  10'd58,   4'b0001, {5'd0, 5'd0, 5'd0, 5'd0}, 16'h0009, 1'b0};
        vecs[2] = '{20'h00001, 10'd50,   10'd10,  10'd59,   4'b0000, 20'd0,                    16'h0000, 1'b0};
        vecs[3] = '{20'h00AA4, 10'd200,  10'd300, 10'd199,  4'b1111, {5'd9, 5'd7, 5'd5, 5'd2}, 16'h0000, 1'b1};
        vecs[4] = '{20'h00000, 10'd0,    10'd0,   10'd300,  4'b0000, 20'd0,                    16'h0000, 1'b0};
        vecs[5] = '{20'h00001, 10'd0,    10'd20,  10'd524,  4'b0001, {5'd0, 5'd0, 5'd0, 5'd0}, 16'h0000, 1'b0};
        vecs[6] = '{20'h00010, 10'd60,   10'd0,   10'd58,   4'b0000, 20'd0,                    16'h0000, 1'b0};
        vecs[7] = '{20'h00042, 10'd100,  10'd5,   10'd104,  4'b0011, {5'd0, 5'd0, 5'd6, 5'd1}, 16'h0055, 1'b0};
        vecs[8] = '{20'h0000F, 10'd10,   10'd40,  10'd18,   4'b1111, {5'd3, 5'd2, 5'd1, 5'd0}, 16'h9999, 1'b0};
        vecs[9] = '{20'h00400, 10'd1020, 10'd700, 10'd1021, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd10}, 16'h0002, 1'b0};

        reset   = 1'b1;
        pix_x   = 10'd0;
        pix_y   = 10'd0;
        nodes_x = '0;
        nodes_y = '0;
        prev_ev   = 4'b0000;
        prev_eovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(slot_valid), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_x", 32'(slot_x), 32'd0);
        check("rst_dy", 32'(slot_dy), 32'd0);
        check("rst_id", 32'(slot_id), 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        for (int v = 0; v < 10; v++) begin
            do_scan($sformatf("v%0d", v), vecs[v].mask, vecs[v].y, vecs[v].xb, vecs[v].py);
            check_list($sformatf("v%0d", v), vecs[v]);
        end

        // Snapshot and retrigger: nodes change at edge 5, second trigger at edge 10.
        @(negedge clk);
        set_nodes(20'h00020, 10'd300, 10'd50);
        pix_y = 10'd299;
        pix_x = 10'd640;
        @(posedge clk);            // edge 0
        busy_cnt = 0;
        for (int e = 0; e <= 30; e++) begin
            if (e > 0) @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            if (e == 4) set_nodes(20'h00100, 10'd300, 10'd50);
            if (e == 6) pix_x = 10'd0;
            if (e == 9) pix_x = 10'd640;
        end
        check("snap_busy_cycles", 32'(busy_cnt), 32'd21);
        va = '{20'h00020, 10'd300, 10'd50, 10'd299, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd5}, 16'h0000, 1'b0};
        check_list("snap", va);
        pix_x = 10'd0;
        repeat (2) @(posedge clk);

        // Reset asserted at edge 8 of a scan.
        @(negedge clk);
        set_nodes(20'h00004, 10'd100, 10'd0);
        pix_y = 10'd100;
        pix_x = 10'd640;
        @(posedge clk);            // edge 0
        for (int e = 1; e <= 7; e++) @(posedge clk);
        #1;
        reset = 1'b1;
        pix_x = 10'd0;
        @(posedge clk);            // edge 8
        #1;
        check("mrst_valid", 32'(slot_valid), 32'd0);
        check("mrst_ovf", 32'(overflow), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_fields", 32'(slot_x) | 32'(slot_dy) | 32'(slot_id), 32'd0);
        reset = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("mrst_nocommit_valid", 32'(slot_valid), 32'd0);
        check("mrst_nocommit_busy", 32'(busy), 32'd0);
        prev_ev   = 4'b0000;
        prev_eovf = 1'b0;
        va = '{20'h00004, 10'd100, 10'd0, 10'd100, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd2}, 16'h0001, 1'b0};
        do_scan("post_rst", va.mask, va.y, va.xb, va.py);
        check_list("post_rst", va);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
